// File: rtl/nios_dbg_pkg.sv
// ---------------------------------------------------------------------------
// nios_dbg_pkg : shared types, widths and helpers for the debug command queue
// Revision 1.0 - initial release
// Optional NIOS_DBG_CMD_PARITY_EN adds one even-parity bit per queued entry.
// ---------------------------------------------------------------------------
`default_nettype none

package nios_dbg_pkg;

    localparam int DEF_SR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

`ifdef NIOS_DBG_CMD_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Entry layout at the default widths; the queue packs entries in the same order.
    typedef struct packed {
        logic [DEF_IR_WIDTH-1:0] ir;
        logic [DEF_SR_WIDTH-1:0] sr;
`ifdef NIOS_DBG_CMD_PARITY_EN
        logic                    parity;
`endif
    } cmd_entry_t;

    function automatic int entry_width(input int ir_w, input int sr_w);
        return ir_w + sr_w + PAR_BITS;
    endfunction

    function automatic int onehot_width(input int ir_w);
        return 1 << ir_w;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The shift-register MSB selects take_action over take_no_action.
    function automatic int action_bit(input int sr_w);
        return sr_w - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nios_dbg_sync_edge.sv
// ---------------------------------------------------------------------------
// nios_dbg_sync_edge : 2-flop synchroniser plus edge flop, rising-edge pulse
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module nios_dbg_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_last;
    logic [2:0] r_vld;

    // r_vld marks which stages hold real samples, so a level already high at
    // reset release is never mistaken for a new edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_last <= 1'b0;
            r_vld  <= 3'b000;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_last <= r_sync;
            r_vld  <= {r_vld[1:0], 1'b1};
        end
    end

    assign rise = r_sync & ~r_last & r_vld[2];

endmodule

`default_nettype wire

// File: rtl/nios_dbg_cmd_queue.sv
// ---------------------------------------------------------------------------
// nios_dbg_cmd_queue : virtual-JTAG update-DR command queue with action decode
// Revision 1.0 - initial release
// Optional NIOS_DBG_CMD_PARITY_EN: per-entry parity, checked on pop (parity_err).
// ---------------------------------------------------------------------------
`default_nettype none

module nios_dbg_cmd_queue
    import nios_dbg_pkg::*;
#(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [IR_WIDTH-1:0]               ir_in,
    input  logic [SR_WIDTH-1:0]               sr,
    input  logic                              vs_udr,
    input  logic                              vs_uir,
    input  logic                              cmd_ready,
    input  logic                              ovf_clr,
    output logic                              cmd_valid,
    output logic [IR_WIDTH-1:0]               cmd_ir,
    output logic [SR_WIDTH-1:0]               jdo,
    output logic [onehot_width(IR_WIDTH)-1:0] take_action,
    output logic [onehot_width(IR_WIDTH)-1:0] take_no_action,
    output logic                              ir_update,
    output logic                              overflow,
    output logic [level_width(DEPTH)-1:0]     level
`ifdef NIOS_DBG_CMD_PARITY_EN
    ,
    output logic                              parity_err
`endif
);

    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_LW      = level_width(DEPTH);
    localparam int c_EW      = entry_width(IR_WIDTH, SR_WIDTH);
    localparam int c_ACT_BIT = action_bit(SR_WIDTH);
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    logic                w_udr_rise;
    logic                w_uir_rise;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;
    logic                w_load_mem;
    logic                w_load_new;
    logic                w_take_en;
    logic [c_EW-1:0]     w_wdata;
    logic [c_EW-1:0]     w_head_src;

    logic [c_EW-1:0]     r_mem [DEPTH];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_LW-1:0]     r_level;
    logic                r_ovf;
    logic [IR_WIDTH-1:0] r_head_ir;
    logic [SR_WIDTH-1:0] r_head_sr;

    nios_dbg_sync_edge u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (w_udr_rise)
    );

    nios_dbg_sync_edge u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (w_uir_rise)
    );

    assign w_full    = (r_level == c_FULL);
    assign w_pop     = cmd_valid & cmd_ready;
    assign w_push_ok = w_udr_rise & (~w_full | w_pop);
    assign w_drop    = w_udr_rise & w_full & ~w_pop;

`ifdef NIOS_DBG_CMD_PARITY_EN
    logic r_head_par;
    logic w_par_bad;

    assign w_wdata   = {ir_in, sr, ^{ir_in, sr}};
    assign w_par_bad = ^{r_head_ir, r_head_sr, r_head_par};
    assign w_take_en = w_pop & ~w_par_bad;
    assign parity_err = w_pop & w_par_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_par <= 1'b0;
        end else if (w_load_mem || w_load_new) begin
            r_head_par <= w_head_src[0];
        end
    end
`else
    assign w_wdata   = {ir_in, sr};
    assign w_take_en = w_pop;
`endif

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // Head is registered so jdo keeps its last value once the queue drains.
    assign w_load_mem = w_pop && (r_level > c_LW'(1));
    assign w_load_new = w_push_ok && ((r_level == '0) || (w_pop && (r_level == c_LW'(1))));
    assign w_head_src = w_load_mem ? r_mem[r_rptr + c_AW'(1)] : w_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_head_ir <= '0;
            r_head_sr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_load_mem || w_load_new) begin
                r_head_ir <= w_head_src[c_EW-1 -: IR_WIDTH];
                r_head_sr <= w_head_src[PAR_BITS +: SR_WIDTH];
            end
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (w_take_en) begin
            if (r_head_sr[c_ACT_BIT]) begin
                take_action[r_head_ir] = 1'b1;
            end else begin
                take_no_action[r_head_ir] = 1'b1;
            end
        end
    end

    assign cmd_valid = (r_level != '0);
    assign cmd_ir    = r_head_ir;
    assign jdo       = r_head_sr;
    assign overflow  = r_ovf;
    assign level     = r_level;
    assign ir_update = w_uir_rise;

endmodule

`default_nettype wire

// File: tb/tb_nios_dbg_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_nios_dbg_cmd_queue : directed self-checking bench for nios_dbg_cmd_queue
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nios_dbg_cmd_queue;
    import nios_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        cmd_ready;
    logic        ovf_clr;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic        overflow;
    logic [2:0]  level;
`ifdef NIOS_DBG_CMD_PARITY_EN
    logic        parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cmd_entry_t exp_q [5];

    nios_dbg_cmd_queue #(.SR_WIDTH(38), .IR_WIDTH(2), .DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .overflow       (overflow),
        .level          (level)
`ifdef NIOS_DBG_CMD_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle update-DR pulse; returns on the falling edge after the push edge.
    task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] d);
        @(negedge clk);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({level, cmd_valid, overflow, ir_update} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctl: got lvl=%0d v=%b ovf=%b iru=%b, want 0", level, cmd_valid, overflow, ir_update); end
        n_cmp++; if ({jdo, cmd_ir} !== 40'b0) begin
            n_err++; $display("FAIL reset_head: got jdo=%h ir=%0d, want 0", jdo, cmd_ir); end
        n_cmp++; if ({take_action, take_no_action} !== 8'b0) begin
            n_err++; $display("FAIL reset_take: got ta=%b tna=%b, want 0", take_action, take_no_action); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Shared timing check: pulse at N0, action visible between edges 3 and 4.
    task automatic pop_one(input string nm, input logic [1:0] ir, input logic [37:0] d,
                           input logic [3:0] exp_ta, input logic [3:0] exp_tna);
        cmd_ready = 1'b1;
        @(negedge clk);
        ir_in = ir; sr = d; vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        n_cmp++; if ({take_action, take_no_action, cmd_valid} !== 9'b0) begin
            n_err++; $display("FAIL %s_e1: got ta=%b tna=%b v=%b, want 0", nm, take_action, take_no_action, cmd_valid); end
        @(negedge clk);
        n_cmp++; if ({take_action, take_no_action, cmd_valid} !== 9'b0) begin
            n_err++; $display("FAIL %s_e2: got ta=%b tna=%b v=%b, want 0", nm, take_action, take_no_action, cmd_valid); end
        @(negedge clk);
        n_cmp++; if (take_action !== exp_ta || take_no_action !== exp_tna || cmd_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_e3: got ta=%b tna=%b v=%b, want ta=%b tna=%b v=1", nm, take_action, take_no_action, cmd_valid, exp_ta, exp_tna); end
        n_cmp++; if (cmd_ir !== ir || jdo !== d) begin
            n_err++; $display("FAIL %s_head: got ir=%0d jdo=%h, want ir=%0d jdo=%h", nm, cmd_ir, jdo, ir, d); end
        @(negedge clk);
        n_cmp++; if ({take_action, take_no_action, cmd_valid, level} !== 12'b0) begin
            n_err++; $display("FAIL %s_e4: got ta=%b tna=%b v=%b lvl=%0d, want 0", nm, take_action, take_no_action, cmd_valid, level); end
        n_cmp++; if (jdo !== d) begin
            n_err++; $display("FAIL %s_hold: got jdo=%h, want %h", nm, jdo, d); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_take_action;
        pop_one("act", 2'd2, {1'b1, 37'h0_1234_5678}, 4'b0100, 4'b0000);
    endtask

    task automatic test_take_no_action;
        pop_one("noact", 2'd1, {1'b0, 37'h1_0F0F_0F0F}, 4'b0000, 4'b0010);
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 5; k++) begin
            exp_q[k].ir = 2'(k);
            exp_q[k].sr = {k[0], 37'(32'h1000 + k)};
            udr_pulse(exp_q[k].ir, exp_q[k].sr);
        end
        n_cmp++; if (level !== 3'd4 || overflow !== 1'b1 || cmd_valid !== 1'b1) begin
            n_err++; $display("FAIL ovf_full: got lvl=%0d ovf=%b v=%b, want 4 1 1", level, overflow, cmd_valid); end
        for (int k = 0; k < 4; k++) begin
            cmd_ready = 1'b1;
            #1;
            n_cmp++; if (cmd_ir !== exp_q[k].ir || jdo !== exp_q[k].sr) begin
                n_err++; $display("FAIL ovf_order%0d: got ir=%0d jdo=%h, want ir=%0d jdo=%h", k, cmd_ir, jdo, exp_q[k].ir, exp_q[k].sr); end
            n_cmp++; if ((exp_q[k].sr[37] ? take_action : take_no_action) !== (4'b0001 << exp_q[k].ir)) begin
                n_err++; $display("FAIL ovf_take%0d: got ta=%b tna=%b, want bit %0d", k, take_action, take_no_action, exp_q[k].ir); end
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        #1;
        n_cmp++; if (level !== 3'd0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky: got lvl=%0d ovf=%b, want 0 1", level, overflow); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr: got %b, want 0", overflow); end
    endtask

    task automatic test_full_push_pop;
        for (int k = 0; k < 5; k++) begin
            exp_q[k].ir = 2'(3 - (k % 4));
            exp_q[k].sr = {~k[0], 37'(32'hA000 + 7 * k)};
        end
        for (int k = 0; k < 4; k++) udr_pulse(exp_q[k].ir, exp_q[k].sr);
        n_cmp++; if (level !== 3'd4) begin
            n_err++; $display("FAIL fpp_pre: got lvl=%0d, want 4", level); end
        @(negedge clk);
        ir_in = exp_q[4].ir; sr = exp_q[4].sr; vs_udr = 1'b1;
        @(negedge clk); vs_udr = 1'b0;
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0;
        #1;
        n_cmp++; if (level !== 3'd4 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fpp_level: got lvl=%0d ovf=%b, want 4 0", level, overflow); end
        for (int k = 1; k < 5; k++) begin
            cmd_ready = 1'b1;
            #1;
            n_cmp++; if (cmd_ir !== exp_q[k].ir || jdo !== exp_q[k].sr) begin
                n_err++; $display("FAIL fpp_order%0d: got ir=%0d jdo=%h, want ir=%0d jdo=%h", k, cmd_ir, jdo, exp_q[k].ir, exp_q[k].sr); end
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        #1;
        n_cmp++; if (level !== 3'd0 || cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL fpp_drain: got lvl=%0d v=%b, want 0 0", level, cmd_valid); end
    endtask

    task automatic test_uir_udr_same_cycle;
        udr_pulse(2'd3, 38'h15_5555_5555);
        @(negedge clk);
        ir_in = 2'd0; sr = 38'h0A_AAAA_AAAA; vs_udr = 1'b1; vs_uir = 1'b1;
        @(negedge clk); vs_udr = 1'b0; vs_uir = 1'b0;
        n_cmp++; if (ir_update !== 1'b0) begin
            n_err++; $display("FAIL uir_early: got %b, want 0", ir_update); end
        @(negedge clk);
        n_cmp++; if (ir_update !== 1'b1 || level !== 3'd1) begin
            n_err++; $display("FAIL uir_pulse: got iru=%b lvl=%0d, want 1 1", ir_update, level); end
        @(negedge clk);
        n_cmp++; if (ir_update !== 1'b0 || level !== 3'd2 || cmd_ir !== 2'd3) begin
            n_err++; $display("FAIL uir_noflush: got iru=%b lvl=%0d ir=%0d, want 0 2 3", ir_update, level, cmd_ir); end
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        cmd_ready = 1'b0;
        n_cmp++; if (level !== 3'd0 || jdo !== 38'h0A_AAAA_AAAA) begin
            n_err++; $display("FAIL uir_drain: got lvl=%0d jdo=%h, want 0 0aaaaaaaaa", level, jdo); end
    endtask

`ifdef NIOS_DBG_CMD_PARITY_EN
    task automatic test_parity;
        logic [1:0]  pir;
        logic [37:0] psr;
        logic        bad;
        pir = 2'd2; psr = {1'b1, 37'h0_0000_0003};
        bad = ~(^{pir, psr});
        udr_pulse(pir, psr);
        force dut.r_head_par = bad;
        cmd_ready = 1'b1;
        #1;
        n_cmp++; if (parity_err !== 1'b1 || take_action !== 4'b0 || take_no_action !== 4'b0) begin
            n_err++; $display("FAIL par_err: got pe=%b ta=%b tna=%b, want 1 0 0", parity_err, take_action, take_no_action); end
        @(negedge clk);
        cmd_ready = 1'b0;
        release dut.r_head_par;
        #1;
        n_cmp++; if (parity_err !== 1'b0 || level !== 3'd0) begin
            n_err++; $display("FAIL par_after: got pe=%b lvl=%0d, want 0 0", parity_err, level); end
    endtask
`endif

    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) udr_pulse(2'(k + 1), {1'b1, 37'(k + 5)});
        n_cmp++; if (level !== 3'd3) begin
            n_err++; $display("FAIL rst_pre: got lvl=%0d, want 3", level); end
        vs_udr = 1'b1;
        #2;
        reset_n = 1'b0;
        cmd_ready = 1'b1;
        #1;
        n_cmp++; if ({level, cmd_valid, overflow, jdo, cmd_ir, take_action, take_no_action} !== 53'b0) begin
            n_err++; $display("FAIL rst_async: got lvl=%0d v=%b jdo=%h ir=%0d ta=%b, want 0", level, cmd_valid, jdo, cmd_ir, take_action); end
        repeat (2) @(negedge clk);
        cmd_ready = 1'b0;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (level !== 3'd0 || cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_held_udr: got lvl=%0d v=%b, want 0 0", level, cmd_valid); end
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (level !== 3'd0) begin
            n_err++; $display("FAIL rst_udr_fall: got lvl=%0d, want 0", level); end
        udr_pulse(2'd1, 38'h3F_0000_0001);
        n_cmp++; if (level !== 3'd1 || cmd_ir !== 2'd1) begin
            n_err++; $display("FAIL rst_resume: got lvl=%0d ir=%0d, want 1 1", level, cmd_ir); end
    endtask

    initial begin
        test_reset();
        test_take_action();
        test_take_no_action();
        test_overflow();
        test_full_push_pop();
        test_uir_udr_same_cycle();
`ifdef NIOS_DBG_CMD_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
